// File: rtl/tower_pkg.sv
// Shared types and constants for the tower turret datapath.
package tower_pkg;

  typedef enum logic [1:0] {
    COOL = 2'd0,
    SCAN = 2'd1,
    FIRE = 2'd2,
    DEAD = 2'd3
  } tower_state_e;

  // Unit numbers are 1-based on the outputs; 0 means no target.
  localparam int IDX_NONE = 0;

  // Width of an unsigned dx^2 + dy^2 for COORD_W-bit screen coordinates.
  function automatic int dist_sq_w(input int coord_w);
    return 2 * coord_w + 3;
  endfunction

endpackage

// File: rtl/tower_turret_if.sv
// Fire request handshake between a tower and the arrow sprite logic.
interface tower_turret_if #(
  parameter int N_UNITS = 4,
  parameter int COORD_W = 10
);
  localparam int IDX_W = $clog2(N_UNITS + 1);

  logic               arrow_on;
  logic [IDX_W-1:0]   attack_index;
  logic [COORD_W-1:0] target_x;
  logic [COORD_W-1:0] target_y;
  logic               fire_ack;

  modport master (
    output arrow_on,
    output attack_index,
    output target_x,
    output target_y,
    input  fire_ack
  );

  modport slave (
    input  arrow_on,
    input  attack_index,
    input  target_x,
    input  target_y,
    output fire_ack
  );

endinterface

// File: rtl/tower_dist_sq.sv
// Squared distance from tower to one unit, plus the attack-radius compare.
module tower_dist_sq
  import tower_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int RANGE   = 100
) (
  input  logic [COORD_W-1:0]              unit_x,
  input  logic [COORD_W-1:0]              unit_y,
  input  logic [COORD_W-1:0]              tower_x,
  input  logic [COORD_W-1:0]              tower_y,
  output logic [dist_sq_w(COORD_W)-1:0]   dist_sq,
  output logic                            in_range
);
  localparam int DIST_W = dist_sq_w(COORD_W);
  localparam logic [DIST_W-1:0] RANGE_SQ = DIST_W'(RANGE * RANGE);

  logic signed [COORD_W:0]     dx;
  logic signed [COORD_W:0]     dy;
  logic signed [2*COORD_W+1:0] dx_sq;
  logic signed [2*COORD_W+1:0] dy_sq;

  always_comb begin
    dx       = $signed({1'b0, unit_x}) - $signed({1'b0, tower_x});
    dy       = $signed({1'b0, unit_y}) - $signed({1'b0, tower_y});
    dx_sq    = dx * dx;
    dy_sq    = dy * dy;
    // Squares are never negative, so zero-extension is safe.
    dist_sq  = DIST_W'($unsigned(dx_sq)) + DIST_W'($unsigned(dy_sq));
    in_range = (dist_sq <= RANGE_SQ);
  end

endmodule

// File: rtl/tower_turret.sv
// Defensive tower: cooldown, sequential nearest-target scan, fire handshake
// and saturating hit-point tracking.
module tower_turret
  import tower_pkg::*;
#(
  parameter int N_UNITS  = 4,
  parameter int COORD_W  = 10,
  parameter int HP_W     = 6,
  parameter int HP_INIT  = 30,
  parameter int DMG_W    = 4,
  parameter int RANGE    = 100,
  parameter int COOLDOWN = 61
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [COORD_W-1:0]                tower_x,
  input  logic [COORD_W-1:0]                tower_y,
  input  logic [N_UNITS-1:0][COORD_W-1:0]   unit_x,
  input  logic [N_UNITS-1:0][COORD_W-1:0]   unit_y,
  input  logic [N_UNITS-1:0]                unit_valid,
  input  logic [N_UNITS-1:0][DMG_W-1:0]     dmg_in,
  tower_turret_if.master                    arrow_bus,
  output logic [HP_W-1:0]                   hp,
  output logic                              destroyed
);
  localparam int IDX_W  = $clog2(N_UNITS + 1);
  localparam int CNT_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int SUM_W  = DMG_W + $clog2(N_UNITS);
  localparam int HS_W   = (HP_W > SUM_W) ? HP_W : SUM_W;
  localparam int DIST_W = dist_sq_w(COORD_W);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(N_UNITS - 1);
  localparam logic [IDX_W-1:0] IDX_NULL = IDX_W'(IDX_NONE);
  localparam logic [HP_W-1:0]  HP_RESET = HP_W'(HP_INIT);

  tower_state_e        state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic                best_valid_reg, best_valid_next;
  logic [IDX_W-1:0]    best_idx_reg, best_idx_next;
  logic [DIST_W-1:0]   best_d2_reg, best_d2_next;
  logic [COORD_W-1:0]  best_x_reg, best_x_next;
  logic [COORD_W-1:0]  best_y_reg, best_y_next;
  logic                arrow_on_reg, arrow_on_next;
  logic [IDX_W-1:0]    attack_index_reg, attack_index_next;
  logic [COORD_W-1:0]  target_x_reg, target_x_next;
  logic [COORD_W-1:0]  target_y_reg, target_y_next;
  logic [HP_W-1:0]     hp_reg, hp_next;
  logic                destroyed_reg, destroyed_next;

  logic [N_UNITS-1:0]            ptr_hit;
  logic [N_UNITS-1:0]            tgt_hit;
  logic [N_UNITS-1:0][SUM_W-1:0] dmg_ext;

  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic               sel_valid;
  logic               tgt_valid;
  logic [SUM_W-1:0]   dmg_sum;
  logic [HP_W-1:0]    hp_after;
  logic [DIST_W-1:0]  dist_sq;
  logic               in_range;
  logic               better;
  logic [IDX_W-1:0]   ptr_unit;

  generate
    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_chan
      assign ptr_hit[gi] = (ptr_reg == IDX_W'(gi));
      assign tgt_hit[gi] = (attack_index_reg == IDX_W'(gi + 1));
      assign dmg_ext[gi] = SUM_W'(dmg_in[gi]);
    end
  endgenerate

  // One-hot selects keep the mux free of out-of-range array indexing.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_valid = 1'b0;
    tgt_valid = 1'b0;
    dmg_sum   = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (ptr_hit[i]) begin
        sel_x     = unit_x[i];
        sel_y     = unit_y[i];
        sel_valid = unit_valid[i];
      end
      if (tgt_hit[i]) begin
        tgt_valid = unit_valid[i];
      end
      dmg_sum = dmg_sum + dmg_ext[i];
    end
  end

  tower_dist_sq #(
    .COORD_W (COORD_W),
    .RANGE   (RANGE)
  ) u_dist (
    .unit_x   (sel_x),
    .unit_y   (sel_y),
    .tower_x  (tower_x),
    .tower_y  (tower_y),
    .dist_sq  (dist_sq),
    .in_range (in_range)
  );

  always_comb begin
    hp_after = (HS_W'(hp_reg) >= HS_W'(dmg_sum)) ?
               HP_W'(HS_W'(hp_reg) - HS_W'(dmg_sum)) : '0;
    // Strict compare: ties keep the earlier (lower-numbered) unit.
    better   = sel_valid && in_range &&
               (!best_valid_reg || (dist_sq < best_d2_reg));
    ptr_unit = ptr_reg + IDX_W'(1);
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    ptr_next          = ptr_reg;
    best_valid_next   = best_valid_reg;
    best_idx_next     = best_idx_reg;
    best_d2_next      = best_d2_reg;
    best_x_next       = best_x_reg;
    best_y_next       = best_y_reg;
    arrow_on_next     = arrow_on_reg;
    attack_index_next = attack_index_reg;
    target_x_next     = target_x_reg;
    target_y_next     = target_y_reg;
    hp_next           = hp_reg;
    destroyed_next    = destroyed_reg;

    case (state_reg)
      COOL: begin
        if (cnt_reg == '0) begin
          state_next      = SCAN;
          ptr_next        = '0;
          best_valid_next = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      SCAN: begin
        if (better) begin
          best_valid_next = 1'b1;
          best_idx_next   = ptr_unit;
          best_d2_next    = dist_sq;
          best_x_next     = sel_x;
          best_y_next     = sel_y;
        end
        if (ptr_reg == PTR_LAST) begin
          if (better || best_valid_reg) begin
            state_next        = FIRE;
            arrow_on_next     = 1'b1;
            attack_index_next = better ? ptr_unit : best_idx_reg;
            target_x_next     = better ? sel_x : best_x_reg;
            target_y_next     = better ? sel_y : best_y_reg;
          end else begin
            state_next        = COOL;
            cnt_next          = CNT_LOAD;
            attack_index_next = IDX_NULL;
          end
        end else begin
          ptr_next = ptr_unit;
        end
      end

      FIRE: begin
        if (arrow_bus.fire_ack) begin
          state_next    = COOL;
          cnt_next      = CNT_LOAD;
          arrow_on_next = 1'b0;
        end else if (!tgt_valid) begin
          state_next        = COOL;
          cnt_next          = CNT_LOAD;
          arrow_on_next     = 1'b0;
          attack_index_next = IDX_NULL;
        end
      end

      default: begin
        arrow_on_next     = 1'b0;
        attack_index_next = IDX_NULL;
        destroyed_next    = 1'b1;
      end
    endcase

    // Damage is live in every state but DEAD; lethal damage overrides the FSM.
    if (state_reg != DEAD) begin
      hp_next = hp_after;
      if (hp_after == '0) begin
        state_next        = DEAD;
        arrow_on_next     = 1'b0;
        attack_index_next = IDX_NULL;
        destroyed_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= COOL;
      cnt_reg          <= CNT_LOAD;
      ptr_reg          <= '0;
      best_valid_reg   <= 1'b0;
      best_idx_reg     <= IDX_NULL;
      best_d2_reg      <= '0;
      best_x_reg       <= '0;
      best_y_reg       <= '0;
      arrow_on_reg     <= 1'b0;
      attack_index_reg <= IDX_NULL;
      target_x_reg     <= '0;
      target_y_reg     <= '0;
      hp_reg           <= HP_RESET;
      destroyed_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      ptr_reg          <= ptr_next;
      best_valid_reg   <= best_valid_next;
      best_idx_reg     <= best_idx_next;
      best_d2_reg      <= best_d2_next;
      best_x_reg       <= best_x_next;
      best_y_reg       <= best_y_next;
      arrow_on_reg     <= arrow_on_next;
      attack_index_reg <= attack_index_next;
      target_x_reg     <= target_x_next;
      target_y_reg     <= target_y_next;
      hp_reg           <= hp_next;
      destroyed_reg    <= destroyed_next;
    end
  end

  assign arrow_bus.arrow_on     = arrow_on_reg;
  assign arrow_bus.attack_index = attack_index_reg;
  assign arrow_bus.target_x     = target_x_reg;
  assign arrow_bus.target_y     = target_y_reg;
  assign hp                     = hp_reg;
  assign destroyed              = destroyed_reg;

endmodule

// File: tb/tb_tower_turret.sv
// Self-checking bench for tower_turret: target-selection table plus
// hand-written cooldown, abort, damage and reset sequences.
module tb_tower_turret;
  localparam int N  = 4;
  localparam int CW = 10;
  localparam int HW = 6;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [CW-1:0]         tower_x, tower_y;
  logic [N-1:0][CW-1:0]  unit_x, unit_y;
  logic [N-1:0]          unit_valid;
  logic [N-1:0][DW-1:0]  dmg_in;
  logic [HW-1:0]         hp;
  logic                  destroyed;

  tower_turret_if #(.N_UNITS(N), .COORD_W(CW)) bus ();

  tower_turret #(
    .N_UNITS(N), .COORD_W(CW), .HP_W(HW), .HP_INIT(30),
    .DMG_W(DW), .RANGE(100), .COOLDOWN(61)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tower_x    (tower_x),
    .tower_y    (tower_y),
    .unit_x     (unit_x),
    .unit_y     (unit_y),
    .unit_valid (unit_valid),
    .dmg_in     (dmg_in),
    .arrow_bus  (bus.master),
    .hp         (hp),
    .destroyed  (destroyed)
  );

  typedef struct {
    logic [CW-1:0]        tx, ty;
    logic [N-1:0][CW-1:0] ux, uy;
    logic [N-1:0]         v;
    int                   idx, ex, ey;
  } vec_t;

  typedef struct {
    int idx, x, y;
  } shot_t;

  vec_t  vecs[10];
  shot_t sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    tower_x    = v.tx;
    tower_y    = v.ty;
    unit_x     = v.ux;
    unit_y     = v.uy;
    unit_valid = v.v;
  endtask

  task automatic start_vec(input vec_t v);
    reset        = 1'b1;
    bus.fire_ack = 1'b0;
    dmg_in       = '0;
    apply_vec(v);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    shot_t s;
    s.idx = v.idx;
    s.x   = v.ex;
    s.y   = v.ey;
    sb.push_back(s);
  endtask

  // Returns the number of rising edges until arrow_on is seen, or -1.
  task automatic wait_shot(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit && n < 0; i++) begin
      @(negedge clk);
      if (bus.arrow_on) n = i;
    end
  endtask

  task automatic compare_shot(input string tag);
    shot_t e;
    check({tag, "_queued"}, int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_index"}, int'(bus.attack_index), e.idx);
      check({tag, "_tx"}, int'(bus.target_x), e.x);
      check({tag, "_ty"}, int'(bus.target_y), e.y);
    end
  endtask

  task automatic ack_shot(input string tag);
    bus.fire_ack = 1'b1;
    @(negedge clk);
    bus.fire_ack = 1'b0;
    check({tag, "_arrow_drop"}, int'(bus.arrow_on), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    int    unstable;
    string tag;

    // Target-selection table; packed unit arrays are {u4, u3, u2, u1}.
    vecs[0] = '{10'd200, 10'd200, {10'd0, 10'd230, 10'd0, 10'd250},
                {10'd0, 10'd210, 10'd0, 10'd200}, 4'b0101, 3, 230, 210};
    vecs[1] = '{10'd200, 10'd200, {10'd0, 10'd0, 10'd200, 10'd300},
                {10'd0, 10'd0, 10'd100, 10'd200}, 4'b0011, 1, 300, 200};
    vecs[2] = '{10'd200, 10'd200, {10'd0, 10'd0, 10'd200, 10'd301},
                {10'd0, 10'd0, 10'd300, 10'd200}, 4'b0011, 2, 200, 300};
    vecs[3] = '{10'd200, 10'd200, {10'd150, 10'd0, 10'd260, 10'd0},
                {10'd160, 10'd0, 10'd260, 10'd0}, 4'b1010, 4, 150, 160};
    vecs[4] = '{10'd200, 10'd200, {10'd0, 10'd210, 10'd0, 10'd200},
                {10'd0, 10'd200, 10'd0, 10'd200}, 4'b0100, 3, 210, 200};
    vecs[5] = '{10'd200, 10'd200, {10'd140, 10'd0, 10'd201, 10'd0},
                {10'd280, 10'd0, 10'd300, 10'd0}, 4'b1010, 4, 140, 280};
    vecs[6] = '{10'd1000, 10'd1000, {10'd0, 10'd0, 10'd0, 10'd1023},
                {10'd0, 10'd0, 10'd0, 10'd1023}, 4'b0011, 1, 1023, 1023};
    vecs[7] = '{10'd200, 10'd200, {10'd0, 10'd0, 10'd0, 10'd301},
                {10'd0, 10'd0, 10'd0, 10'd200}, 4'b0001, 0, 0, 0};
    vecs[8] = '{10'd200, 10'd200, {10'd200, 10'd200, 10'd200, 10'd200},
                {10'd200, 10'd200, 10'd200, 10'd200}, 4'b0000, 0, 0, 0};
    vecs[9] = '{10'd200, 10'd200, {10'd205, 10'd205, 10'd205, 10'd205},
                {10'd200, 10'd200, 10'd200, 10'd200}, 4'b1111, 1, 205, 200};

    // Reset values while reset is held.
    start_vec(vecs[8]);
    reset = 1'b1;
    @(negedge clk);
    check("rst_arrow_on", int'(bus.arrow_on), 0);
    check("rst_index", int'(bus.attack_index), 0);
    check("rst_tx", int'(bus.target_x), 0);
    check("rst_ty", int'(bus.target_y), 0);
    check("rst_hp", int'(hp), 30);
    check("rst_destroyed", int'(destroyed), 0);

    // No valid units: never fires.
    start_vec(vecs[8]);
    wait_shot(500, n);
    check("idle_no_shot", n, -1);
    check("idle_hp", int'(hp), 30);
    check("idle_destroyed", int'(destroyed), 0);

    // Table: each vector from reset, first shot expected 65 edges in.
    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      start_vec(vecs[i]);
      if (vecs[i].idx != 0) push_exp(vecs[i]);
      wait_shot(80, n);
      if (vecs[i].idx != 0) begin
        check({tag, "_shot_cycle"}, n, 65);
        if (n > 0) begin
          compare_shot(tag);
          ack_shot(tag);
        end
      end else begin
        check({tag, "_no_shot"}, n, -1);
        check({tag, "_index_none"}, int'(bus.attack_index), 0);
      end
      $display("vector %0d: target %0d at (%0d,%0d), shot after %0d cycles",
               i, vecs[i].idx, vecs[i].ex, vecs[i].ey, n);
    end

    // Minimum shot period, long hold without ack, abort on target loss.
    start_vec(vecs[0]);
    push_exp(vecs[0]);
    wait_shot(80, n);
    check("seq_first_shot", n, 65);
    compare_shot("seq_first");
    ack_shot("seq_first");
    push_exp(vecs[0]);
    wait_shot(80, n);
    check("seq_shot_period", n, 65);
    compare_shot("seq_second");
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.attack_index != 3 || !bus.arrow_on) unstable++;
    end
    check("seq_hold_stable", unstable, 0);
    unit_valid[2] = 1'b0;
    @(negedge clk);
    check("seq_abort_arrow", int'(bus.arrow_on), 0);
    check("seq_abort_index", int'(bus.attack_index), 0);
    unit_valid[2] = 1'b1;
    push_exp(vecs[0]);
    wait_shot(80, n);
    check("seq_reshot_cycle", n, 65);
    compare_shot("seq_reshot");
    ack_shot("seq_reshot");
    $display("sequence hold/abort: reshot after %0d cycles", n);

    // Saturating damage to zero, then the tower stays dead.
    start_vec(vecs[8]);
    dmg_in = {4'd7, 4'd7, 4'd7, 4'd7};
    @(negedge clk);
    dmg_in = {4'd0, 4'd1, 4'd1, 4'd1};
    check("dmg_hp_after_28", int'(hp), 2);
    @(negedge clk);
    dmg_in = '0;
    check("dmg_hp_zero", int'(hp), 0);
    check("dmg_destroyed", int'(destroyed), 1);
    apply_vec(vecs[0]);
    wait_shot(150, n);
    check("dead_no_shot", n, -1);
    check("dead_destroyed_held", int'(destroyed), 1);
    start_vec(vecs[8]);
    @(negedge clk);
    check("revive_hp", int'(hp), 30);
    check("revive_destroyed", int'(destroyed), 0);
    $display("sequence damage: hp restored to %0d", hp);

    // Lethal damage on the ack cycle.
    start_vec(vecs[0]);
    push_exp(vecs[0]);
    wait_shot(80, n);
    check("lethal_shot_cycle", n, 65);
    compare_shot("lethal");
    bus.fire_ack = 1'b1;
    dmg_in = {4'd0, 4'd0, 4'd15, 4'd15};
    @(negedge clk);
    bus.fire_ack = 1'b0;
    dmg_in = '0;
    check("lethal_arrow", int'(bus.arrow_on), 0);
    check("lethal_destroyed", int'(destroyed), 1);
    check("lethal_hp", int'(hp), 0);
    check("lethal_index", int'(bus.attack_index), 0);
    $display("sequence lethal+ack: destroyed=%0d", destroyed);

    // Async reset asserted in the middle of a scan.
    start_vec(vecs[0]);
    push_exp(vecs[0]);
    wait_shot(80, n);
    check("midscan_shot_cycle", n, 65);
    compare_shot("midscan");
    bus.fire_ack = 1'b1;
    dmg_in = {4'd0, 4'd0, 4'd0, 4'd3};
    @(negedge clk);
    bus.fire_ack = 1'b0;
    dmg_in = '0;
    check("midscan_arrow_drop", int'(bus.arrow_on), 0);
    check("midscan_hp_27", int'(hp), 27);
    repeat (62) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midscan_rst_arrow", int'(bus.arrow_on), 0);
    check("midscan_rst_index", int'(bus.attack_index), 0);
    check("midscan_rst_tx", int'(bus.target_x), 0);
    check("midscan_rst_ty", int'(bus.target_y), 0);
    check("midscan_rst_hp", int'(hp), 30);
    check("midscan_rst_destroyed", int'(destroyed), 0);
    $display("sequence mid-scan reset: hp=%0d arrow_on=%0d", hp, bus.arrow_on);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
